// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller: steps a tuning word from a start value by a fixed increment with a per-word dwell.
// Optional macro DDS_SWEEP_PINGPONG_EN: after the last increment the sweep reverses back to the start word.
module dds_sweep_ctrl #(
    parameter int FTW_W   = 32,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FTW_W-1:0]   cmd_ftw_start,
    input  logic [FTW_W-1:0]   cmd_ftw_step,
    input  logic [CNT_W-1:0]   cmd_steps,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_mode,
    input  logic               abort,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_valid,
    output logic               mode,
    output logic               phase_clr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DWELL_W-1:0] DW_ZERO  = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DW_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [FTW_W-1:0]   ftw_r, ftw_s;
    logic [FTW_W-1:0]   step_r, step_s;
    logic [CNT_W-1:0]   remaining_r, remaining_s;
    logic [DWELL_W-1:0] dwell_len_r, dwell_len_s;   // dwell length minus one
    logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_s;   // cycles left for the current word
    logic               mode_r, mode_s;
    logic               ftw_valid_r, ftw_valid_s;
    logic               phase_clr_r, phase_clr_s;
    logic               busy_r, done_r;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic               dir_r, dir_s;
    logic [CNT_W-1:0]   steps_r, steps_s;
`endif

    // Ready only in IDLE, and never while reset is held.
    assign cmd_ready = (state_r == IDLE) && !reset;

    // Next-state and next-value logic for the sweep sequencer.
    always_comb begin
        state_s     = state_r;
        ftw_s       = ftw_r;
        step_s      = step_r;
        remaining_s = remaining_r;
        dwell_len_s = dwell_len_r;
        dwell_cnt_s = dwell_cnt_r;
        mode_s      = mode_r;
        ftw_valid_s = 1'b0;
        phase_clr_s = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        dir_s       = dir_r;
        steps_s     = steps_r;
`endif
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_s     = LOAD;
                    ftw_s       = cmd_ftw_start;
                    step_s      = cmd_ftw_step;
                    remaining_s = cmd_steps;
                    dwell_len_s = (cmd_dwell == DW_ZERO) ? DW_ZERO : (cmd_dwell - DW_ONE);
                    dwell_cnt_s = dwell_len_s;
                    mode_s      = cmd_mode;
                    ftw_valid_s = 1'b1;
                    phase_clr_s = 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                    dir_s       = 1'b0;
                    steps_s     = cmd_steps;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            // Dwell expiry is evaluated in LOAD too so a one-cycle dwell advances straight away.
            LOAD, DWELL: begin
                if (abort) begin
                    state_s = DONE;
                end else if (dwell_cnt_r != DW_ZERO) begin
                    dwell_cnt_s = dwell_cnt_r - DW_ONE;
                    state_s     = DWELL;
                end else if (remaining_r != CNT_ZERO) begin
`ifdef DDS_SWEEP_PINGPONG_EN
                    ftw_s       = dir_r ? (ftw_r - step_r) : (ftw_r + step_r);
`else
                    ftw_s       = ftw_r + step_r;
`endif
                    remaining_s = remaining_r - CNT_ONE;
                    dwell_cnt_s = dwell_len_r;
                    ftw_valid_s = 1'b1;
                    state_s     = DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
                end else if (!dir_r && (steps_r != CNT_ZERO)) begin
                    dir_s       = 1'b1;
                    ftw_s       = ftw_r - step_r;
                    remaining_s = steps_r - CNT_ONE;
                    dwell_cnt_s = dwell_len_r;
                    ftw_valid_s = 1'b1;
                    state_s     = DWELL;
`endif
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; status flags are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            ftw_r       <= {FTW_W{1'b0}};
            step_r      <= {FTW_W{1'b0}};
            remaining_r <= CNT_ZERO;
            dwell_len_r <= DW_ZERO;
            dwell_cnt_r <= DW_ZERO;
            mode_r      <= 1'b0;
            ftw_valid_r <= 1'b0;
            phase_clr_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ftw_r       <= ftw_s;
            step_r      <= step_s;
            remaining_r <= remaining_s;
            dwell_len_r <= dwell_len_s;
            dwell_cnt_r <= dwell_cnt_s;
            mode_r      <= mode_s;
            ftw_valid_r <= ftw_valid_s;
            phase_clr_r <= phase_clr_s;
            busy_r      <= (state_s == LOAD) || (state_s == DWELL);
            done_r      <= (state_s == DONE);
        end
    end

`ifdef DDS_SWEEP_PINGPONG_EN
    // Direction and step-count registers for the return leg.
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_r   <= 1'b0;
            steps_r <= CNT_ZERO;
        end else begin
            dir_r   <= dir_s;
            steps_r <= steps_s;
        end
    end
`endif

    assign ftw       = ftw_r;
    assign ftw_valid = ftw_valid_r;
    assign mode      = mode_r;
    assign phase_clr = phase_clr_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps against a word-list reference model.
module tb_dds_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_ftw_start;
    logic [31:0] cmd_ftw_step;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_dwell;
    logic        cmd_mode;
    logic        abort;
    logic [31:0] ftw;
    logic        ftw_valid;
    logic        mode;
    logic        phase_clr;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    dds_sweep_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ftw_start(cmd_ftw_start),
        .cmd_ftw_step (cmd_ftw_step),
        .cmd_steps    (cmd_steps),
        .cmd_dwell    (cmd_dwell),
        .cmd_mode     (cmd_mode),
        .abort        (abort),
        .ftw          (ftw),
        .ftw_valid    (ftw_valid),
        .mode         (mode),
        .phase_clr    (phase_clr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one sweep and check every cycle from LOAD to one cycle after DONE.
    task automatic run_cmd(input logic [31:0] st, input logic [31:0] sp, input logic [15:0] ns,
                           input logic [15:0] nd, input logic md, input int abort_at,
                           input bit abort_on_accept);
        logic [31:0] words[$];
        int d, total, end_c, guard;
        words.delete();
        d = (nd == 16'd0) ? 1 : int'(nd);
        for (int k = 0; k <= int'(ns); k++) words.push_back(st + sp * 32'(k));
`ifdef DDS_SWEEP_PINGPONG_EN
        for (int k = int'(ns) - 1; k >= 0; k--) words.push_back(st + sp * 32'(k));
`endif
        total = words.size() * d;
        end_c = (abort_at >= 0 && abort_at < total) ? abort_at + 1 : total;

        guard = 0;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("ready_before_cmd", cmd_ready, 1'b1);

        cmd_valid     = 1'b1;
        cmd_ftw_start = st;
        cmd_ftw_step  = sp;
        cmd_steps     = ns;
        cmd_dwell     = nd;
        cmd_mode      = md;
        abort         = abort_on_accept;
        tick();
        abort = 1'b0;

        for (int c = 0; c <= end_c; c++) begin
            if (c > 0) tick();
            // Foreign commands during the sweep must be ignored.
            cmd_valid     = 1'($urandom_range(0, 1));
            cmd_ftw_start = $urandom;
            cmd_ftw_step  = $urandom;
            cmd_steps     = 16'($urandom_range(0, 7));
            cmd_dwell     = 16'($urandom_range(0, 7));
            cmd_mode      = ~md;
            if (c < end_c) begin
                chk("ftw", ftw, words[c / d]);
                chk("ftw_valid", ftw_valid, (c % d) == 0);
                chk("phase_clr", phase_clr, c == 0);
                chk("busy", busy, 1'b1);
                chk("done_early", done, 1'b0);
                chk("ready_busy", cmd_ready, 1'b0);
                chk("mode", mode, md);
            end else begin
                chk("ftw_done", ftw, words[(end_c - 1) / d]);
                chk("ftw_valid_done", ftw_valid, 1'b0);
                chk("done", done, 1'b1);
                chk("busy_done", busy, 1'b0);
                chk("ready_done", cmd_ready, 1'b0);
                chk("mode_done", mode, md);
            end
            abort = (c == abort_at) ? 1'b1 : 1'b0;
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        tick();
        chk("done_after", done, 1'b0);
        chk("ready_after", cmd_ready, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("ftw_hold_idle", ftw, words[(end_c - 1) / d]);
        chk("mode_hold_idle", mode, md);
    endtask

    initial begin
        int ab;
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_ftw_start = 32'd0;
        cmd_ftw_step  = 32'd0;
        cmd_steps     = 16'd0;
        cmd_dwell     = 16'd0;
        cmd_mode      = 1'b0;
        abort         = 1'b0;
        tick();
        tick();
        chk("rst_ftw", ftw, 32'd0);
        chk("rst_ftw_valid", ftw_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Directed cases: basic sweep, wraparound, zero dwell with negative step, abort, return-leg case.
        run_cmd(32'd100, 32'd10, 16'd3, 16'd2, 1'b0, -1, 1'b0);
        run_cmd(32'hFFFF_FFF0, 32'h20, 16'd1, 16'd1, 1'b1, -1, 1'b0);
        run_cmd(32'd50, 32'hFFFF_FFFB, 16'd2, 16'd0, 1'b0, -1, 1'b0);
        run_cmd(32'd100, 32'd10, 16'd3, 16'd2, 1'b1, 3, 1'b0);
        run_cmd(32'd100, 32'd10, 16'd2, 16'd1, 1'b0, -1, 1'b0);
        run_cmd(32'd7, 32'd3, 16'd0, 16'd1, 1'b1, -1, 1'b1);
        run_cmd(32'd9, 32'd1, 16'd2, 16'd3, 1'b0, 0, 1'b0);

        // Reset mid-sweep with a command and abort also asserted.
        run_cmd(32'd1, 32'd1, 16'd0, 16'd1, 1'b0, -1, 1'b0);
        cmd_valid     = 1'b1;
        cmd_ftw_start = 32'd100;
        cmd_ftw_step  = 32'd10;
        cmd_steps     = 16'd3;
        cmd_dwell     = 16'd2;
        cmd_mode      = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1'b1);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        abort     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mid_rst_ftw", ftw, 32'd0);
            chk("mid_rst_ftw_valid", ftw_valid, 1'b0);
            chk("mid_rst_mode", mode, 1'b0);
            chk("mid_rst_phase_clr", phase_clr, 1'b0);
            chk("mid_rst_busy", busy, 1'b0);
            chk("mid_rst_done", done, 1'b0);
            chk("mid_rst_ready", cmd_ready, 1'b0);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_busy", busy, 1'b0);

        // Random sweeps, some aborted, some with abort on the accept edge.
        for (int n = 0; n < 40; n++) begin
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_cmd($urandom, $urandom, 16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
